// File: rtl/axis_frame_rr_sched_64_pkg.sv
// Shared types and helpers for the round-robin AXI-stream frame scheduler.
package axis_frame_rr_sched_64_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FORWARD = 2'd1,
        ST_DROP    = 2'd2
    } sched_state_t;

    localparam int MAX_PORTS  = 8;
    localparam int PORT_IDX_W = 3;
    localparam int CNT_W      = 16;

    function automatic logic [PORT_IDX_W-1:0] onehot_to_idx(input logic [MAX_PORTS-1:0] oh);
        logic [PORT_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (oh[i]) idx = PORT_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/arbiter_rr.sv
// Round-robin priority encoder: first requester strictly after base, wrapping.
module arbiter_rr
    import axis_frame_rr_sched_64_pkg::*;
#(
    parameter int PORTS = 4
) (
    input  logic [PORTS-1:0]      req,
    input  logic [PORT_IDX_W-1:0] base,
    output logic [PORTS-1:0]      grant
);

    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 1; k <= PORTS; k++) begin
            if (!found && req[(int'(base) + k) % PORTS]) begin
                grant[(int'(base) + k) % PORTS] = 1'b1;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_frame_rr_sched_64.sv
// Frame-granular round-robin scheduler of PORTS AXI streams onto one registered output.
//   state      | meaning
//   ST_IDLE    | no owner, all inputs stalled, arbitrate among requesters
//   ST_FORWARD | granted port's words pass through output register / skid buffer
//   ST_DROP    | frame exceeded MAX_FRAME_WORDS, swallow words until tlast
module axis_frame_rr_sched_64
    import axis_frame_rr_sched_64_pkg::*;
#(
    parameter int PORTS           = 4,
    parameter int DATA_WIDTH      = 64,
    parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
    parameter int MAX_FRAME_WORDS = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PORTS*DATA_WIDTH-1:0]   input_axis_tdata,
    input  logic [PORTS*KEEP_WIDTH-1:0]   input_axis_tkeep,
    input  logic [PORTS-1:0]              input_axis_tvalid,
    input  logic [PORTS-1:0]              input_axis_tlast,
    input  logic [PORTS-1:0]              input_axis_tuser,
    output logic [PORTS-1:0]              input_axis_tready,
    output logic [DATA_WIDTH-1:0]         output_axis_tdata,
    output logic [KEEP_WIDTH-1:0]         output_axis_tkeep,
    output logic                          output_axis_tvalid,
    output logic                          output_axis_tlast,
    output logic                          output_axis_tuser,
    input  logic                          output_axis_tready,
    output logic [PORTS-1:0]              grant,
    output logic                          grant_valid,
    output logic                          error_oversize
);

    localparam logic [CNT_W-1:0] LAST_WORD_IDX = CNT_W'(MAX_FRAME_WORDS - 1);

    sched_state_t          state, state_next;
    logic [PORTS-1:0]      grant_reg, grant_next, arb_grant;
    logic [PORT_IDX_W-1:0] last_grant, last_grant_next;
    logic [CNT_W-1:0]      word_cnt, word_cnt_next;

    logic [DATA_WIDTH-1:0] sel_data;
    logic [KEEP_WIDTH-1:0] sel_keep;
    logic                  sel_valid, sel_last, sel_user;
    logic                  port_ready, accept, fwd_accept, oversize;
    logic                  wr_last, wr_user;

    logic [DATA_WIDTH-1:0] out_data, skid_data;
    logic [KEEP_WIDTH-1:0] out_keep, skid_keep;
    logic                  out_valid, out_last, out_user;
    logic                  skid_valid, skid_last, skid_user;
    logic                  err_reg;

    arbiter_rr #(.PORTS(PORTS)) u_arbiter (
        .req   (input_axis_tvalid),
        .base  (last_grant),
        .grant (arb_grant)
    );

    always_comb begin
        sel_data  = '0;
        sel_keep  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_user  = 1'b0;
        for (int i = 0; i < PORTS; i++) begin
            if (grant_reg[i]) begin
                sel_data  = input_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_keep  = input_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
                sel_valid = input_axis_tvalid[i];
                sel_last  = input_axis_tlast[i];
                sel_user  = input_axis_tuser[i];
            end
        end
    end

    // Ready comes only from registers: the skid slot absorbs the word accepted during a stall.
    assign port_ready        = (state == ST_FORWARD) ? !skid_valid : (state == ST_DROP);
    assign input_axis_tready = port_ready ? grant_reg : '0;
    assign accept            = sel_valid && port_ready;
    assign fwd_accept        = accept && (state == ST_FORWARD);
    assign oversize          = fwd_accept && !sel_last && (word_cnt == LAST_WORD_IDX);
    assign wr_last           = sel_last | oversize;
    assign wr_user           = sel_user | oversize;

    always_comb begin
        state_next      = state;
        grant_next      = grant_reg;
        last_grant_next = last_grant;
        word_cnt_next   = word_cnt;
        unique case (state)
            ST_IDLE: begin
                if (|input_axis_tvalid) begin
                    grant_next    = arb_grant;
                    word_cnt_next = '0;
                    state_next    = ST_FORWARD;
                end
            end
            ST_FORWARD: begin
                if (fwd_accept) begin
                    word_cnt_next = word_cnt + 1'b1;
                    if (sel_last) begin
                        last_grant_next = onehot_to_idx(MAX_PORTS'(grant_reg));
                        grant_next      = '0;
                        state_next      = ST_IDLE;
                    end else if (oversize) begin
                        state_next = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                if (accept && sel_last) begin
                    last_grant_next = onehot_to_idx(MAX_PORTS'(grant_reg));
                    grant_next      = '0;
                    state_next      = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            grant_reg  <= '0;
            last_grant <= PORT_IDX_W'(PORTS - 1);
            word_cnt   <= '0;
        end else begin
            state      <= state_next;
            grant_reg  <= grant_next;
            last_grant <= last_grant_next;
            word_cnt   <= word_cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_keep   <= '0;
            out_last   <= 1'b0;
            out_user   <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_keep  <= '0;
            skid_last  <= 1'b0;
            skid_user  <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            err_reg <= oversize;
            if (fwd_accept) begin
                if (!out_valid || output_axis_tready) begin
                    out_valid <= 1'b1;
                    out_data  <= sel_data;
                    out_keep  <= sel_keep;
                    out_last  <= wr_last;
                    out_user  <= wr_user;
                end else begin
                    skid_valid <= 1'b1;
                    skid_data  <= sel_data;
                    skid_keep  <= sel_keep;
                    skid_last  <= wr_last;
                    skid_user  <= wr_user;
                end
            end else if (output_axis_tready) begin
                if (skid_valid) begin
                    out_data   <= skid_data;
                    out_keep   <= skid_keep;
                    out_last   <= skid_last;
                    out_user   <= skid_user;
                    skid_valid <= 1'b0;
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

    assign output_axis_tdata  = out_data;
    assign output_axis_tkeep  = out_keep;
    assign output_axis_tvalid = out_valid;
    assign output_axis_tlast  = out_last;
    assign output_axis_tuser  = out_user;
    assign grant              = grant_reg;
    assign grant_valid        = (state != ST_IDLE);
    assign error_oversize     = err_reg;

endmodule
